// File: rtl/wave_arb_pkg.sv
// Shared types for the wave read arbiter: requester tags and tag-pipeline entries.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package wave_arb_pkg;

    // Tags are carried at a fixed width that is wide enough for any practical voice
    // count. The minimum width a given NUM_OSC needs is given by tag_width().
    localparam int TAG_W = 8;

    function automatic int tag_width(input int num_osc);
        return $clog2(num_osc + 2);
    endfunction

    // Oscillators use tags 0..NUM_OSC-1. The visualiser and the debugger take the next two.
    function automatic logic [TAG_W-1:0] tag_viz(input int num_osc);
        return TAG_W'(num_osc);
    endfunction

    function automatic logic [TAG_W-1:0] tag_dbg(input int num_osc);
        return TAG_W'(num_osc + 1);
    endfunction

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } tag_ent_t;

endpackage

// File: rtl/wave_read_arbiter_rr.sv
// Round-robin arbiter. It returns a one-hot grant for the first request at or after the pointer.
// Latency: the grant is combinational. The pointer moves to winner+1 at the edge where a grant is issued.
// Backpressure: en_i low suppresses the grant and freezes the pointer. Requests stay pending.
// Ports: clk_i/rst_ni clock and async active-low reset, en_i grant enable,
//        req_i request vector, gnt_o one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx, win;
    logic          found;
    int            s;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        s     = 0;
        // Scan from the pointer, wrapping N-1 -> 0.
        for (int k = 0; k < N; k++) begin
            s = int'(ptr_q) + k;
            if (s >= N) s = s - N;
            idx = PW'(s);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        ptr_d = ptr_q;
        if (en_i && found) begin
            gnt_o[win] = 1'b1;
            ptr_d      = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/wave_read_arbiter.sv
// Wave BRAM read-port arbiter for NUM_OSC voices, the visualiser and the debugger.
// Latency: ack (comb) -> registered BRAM read -> data/valid READ_LATENCY+2 cycles after the ack.
//          Full throughput. Returns come back in grant order.
// Backpressure: no acks while load_busy_in or reset. Starved viz/dbg get a forced grant at STARVE_LIMIT.
// Ports: per requester req/addr in, ack/valid/data out. bram_en/addr out (registered) and bram_data in.
module wave_read_arbiter
    import wave_arb_pkg::*;
#(
    parameter int NUM_OSC      = 4,
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                load_busy_in,
    input  logic [NUM_OSC-1:0]                  osc_req_in,
    input  logic [NUM_OSC-1:0][ADDR_WIDTH-1:0]  osc_addr_in,
    output logic [NUM_OSC-1:0]                  osc_ack_out,
    output logic [NUM_OSC-1:0]                  osc_valid_out,
    output logic [NUM_OSC-1:0][DATA_WIDTH-1:0]  osc_data_out,
    input  logic                                viz_req_in,
    input  logic [ADDR_WIDTH-1:0]               viz_addr_in,
    output logic                                viz_ack_out,
    output logic                                viz_valid_out,
    output logic [DATA_WIDTH-1:0]               viz_data_out,
    input  logic                                dbg_req_in,
    input  logic [ADDR_WIDTH-1:0]               dbg_addr_in,
    output logic                                dbg_ack_out,
    output logic                                dbg_valid_out,
    output logic [DATA_WIDTH-1:0]               dbg_data_out,
    output logic                                bram_en_out,
    output logic [ADDR_WIDTH-1:0]               bram_addr_out,
    input  logic [DATA_WIDTH-1:0]               bram_data_in
);
    localparam int             CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]           viz_cnt_q, viz_cnt_d, dbg_cnt_q, dbg_cnt_d;
    logic                    grant_ok, force_viz, force_dbg, osc_en, any_osc, any_grant;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [TAG_W-1:0]        sel_tag;
    logic                    bram_en_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    tag_ent_t                pipe_q [READ_LATENCY+1];
    tag_ent_t                ret;
    logic [NUM_OSC-1:0]                  osc_valid_q;
    logic [NUM_OSC-1:0][DATA_WIDTH-1:0]  osc_data_q;
    logic                    viz_valid_q, dbg_valid_q;
    logic [DATA_WIDTH-1:0]   viz_data_q, dbg_data_q;

    // Acks are combinational, so reset also has to mask them directly.
    assign grant_ok  = rst_in && !load_busy_in;
    assign force_viz = grant_ok && viz_req_in && (viz_cnt_q == LIMIT);
    assign force_dbg = grant_ok && !force_viz && dbg_req_in && (dbg_cnt_q == LIMIT);
    assign osc_en    = grant_ok && !force_viz && !force_dbg;

    rr_arbiter #(.N(NUM_OSC)) u_osc_rr (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .en_i   (osc_en),
        .req_i  (osc_req_in),
        .gnt_o  (osc_ack_out)
    );

    assign any_osc     = |osc_ack_out;
    assign viz_ack_out = force_viz || (osc_en && !any_osc && viz_req_in);
    assign dbg_ack_out = force_dbg || (osc_en && !any_osc && !viz_req_in && dbg_req_in);
    assign any_grant   = any_osc || viz_ack_out || dbg_ack_out;

    // A counter clears on ack or when the request drops. It freezes while the loader is busy
    // and saturates at LIMIT.
    function automatic logic [CW-1:0] starve_next(input logic [CW-1:0] cnt,
                                                  input logic req, input logic ack,
                                                  input logic busy);
        if (!req || ack)             return '0;
        else if (busy || cnt == LIMIT) return cnt;
        else                         return cnt + 1'b1;
    endfunction

    assign viz_cnt_d = starve_next(viz_cnt_q, viz_req_in, viz_ack_out, load_busy_in);
    assign dbg_cnt_d = starve_next(dbg_cnt_q, dbg_req_in, dbg_ack_out, load_busy_in);

    always_comb begin
        sel_addr = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_OSC; i++) begin
            if (osc_ack_out[i]) begin
                sel_addr = osc_addr_in[i];
                sel_tag  = TAG_W'(i);
            end
        end
        if (viz_ack_out) begin
            sel_addr = viz_addr_in;
            sel_tag  = tag_viz(NUM_OSC);
        end
        if (dbg_ack_out) begin
            sel_addr = dbg_addr_in;
            sel_tag  = tag_dbg(NUM_OSC);
        end
    end

    // The tag entering at the grant edge reaches the last stage at the same time as the BRAM data
    // for its address.
    assign ret = pipe_q[READ_LATENCY];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            viz_cnt_q   <= '0;
            dbg_cnt_q   <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) pipe_q[i] <= '0;
            osc_valid_q <= '0;
            osc_data_q  <= '0;
            viz_valid_q <= 1'b0;
            viz_data_q  <= '0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            viz_cnt_q <= viz_cnt_d;
            dbg_cnt_q <= dbg_cnt_d;
            bram_en_q <= any_grant;
            if (any_grant) bram_addr_q <= sel_addr;
            pipe_q[0] <= '{vld: any_grant, tag: sel_tag};
            for (int i = 1; i <= READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            for (int i = 0; i < NUM_OSC; i++) begin
                osc_valid_q[i] <= ret.vld && (ret.tag == TAG_W'(i));
                if (ret.vld && (ret.tag == TAG_W'(i))) osc_data_q[i] <= bram_data_in;
            end
            viz_valid_q <= ret.vld && (ret.tag == tag_viz(NUM_OSC));
            if (ret.vld && (ret.tag == tag_viz(NUM_OSC))) viz_data_q <= bram_data_in;
            dbg_valid_q <= ret.vld && (ret.tag == tag_dbg(NUM_OSC));
            if (ret.vld && (ret.tag == tag_dbg(NUM_OSC))) dbg_data_q <= bram_data_in;
        end
    end

    assign bram_en_out   = bram_en_q;
    assign bram_addr_out = bram_addr_q;
    assign osc_valid_out = osc_valid_q;
    assign osc_data_out  = osc_data_q;
    assign viz_valid_out = viz_valid_q;
    assign viz_data_out  = viz_data_q;
    assign dbg_valid_out = dbg_valid_q;
    assign dbg_data_out  = dbg_data_q;

endmodule

// File: tb/tb_wave_read_arbiter.sv
// Directed bench for wave_read_arbiter with default parameters.
// The BRAM model returns addr[15:0]^0xA5A5 two cycles after bram_addr_out is presented.
// Expected returns are scheduled 4 cycles after each expected ack.
module tb_wave_read_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b1;
    logic             load_busy;
    logic [3:0]       osc_req, osc_ack, osc_valid;
    logic [3:0][17:0] osc_addr;
    logic [3:0][15:0] osc_data;
    logic             viz_req, viz_ack, viz_valid;
    logic [17:0]      viz_addr;
    logic [15:0]      viz_data;
    logic             dbg_req, dbg_ack, dbg_valid;
    logic [17:0]      dbg_addr;
    logic [15:0]      dbg_data;
    logic             bram_en;
    logic [17:0]      bram_addr;
    logic [15:0]      bram_data, bram_s1;

    wave_read_arbiter dut (
        .clk_in(clk), .rst_in(rst_n), .load_busy_in(load_busy),
        .osc_req_in(osc_req), .osc_addr_in(osc_addr), .osc_ack_out(osc_ack),
        .osc_valid_out(osc_valid), .osc_data_out(osc_data),
        .viz_req_in(viz_req), .viz_addr_in(viz_addr), .viz_ack_out(viz_ack),
        .viz_valid_out(viz_valid), .viz_data_out(viz_data),
        .dbg_req_in(dbg_req), .dbg_addr_in(dbg_addr), .dbg_ack_out(dbg_ack),
        .dbg_valid_out(dbg_valid), .dbg_data_out(dbg_data),
        .bram_en_out(bram_en), .bram_addr_out(bram_addr), .bram_data_in(bram_data)
    );

    // BRAM with READ_LATENCY = 2.
    always @(posedge clk) begin
        bram_s1   <= bram_addr[15:0] ^ 16'hA5A5;
        bram_data <= bram_s1;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [5:0]  e_mask [16];   // {dbg, viz, osc3..osc0} valid expected in that cycle slot
    logic [15:0] e_data [16];

    typedef struct {
        logic [3:0] oreq;
        logic       vreq, dreq, busy;
        logic [3:0] e_osc;
        logic       e_viz, e_dbg;
    } vec_t;
    vec_t vt [$];

    function automatic vec_t mk(input logic [3:0] oreq, input logic vreq, input logic dreq,
                                input logic busy, input logic [3:0] e_osc,
                                input logic e_viz, input logic e_dbg);
        vec_t v;
        v.oreq = oreq; v.vreq = vreq; v.dreq = dreq; v.busy = busy;
        v.e_osc = e_osc; v.e_viz = e_viz; v.e_dbg = e_dbg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive requests, check acks at the negedge, schedule and check returns.
    task automatic step(input logic [3:0] oreq, input logic vreq, input logic dreq,
                        input logic busy, input logic [3:0] e_osc,
                        input logic e_viz, input logic e_dbg);
        int s;
        osc_req = oreq; viz_req = vreq; dbg_req = dreq; load_busy = busy;
        @(negedge clk);
        chk("ack", {osc_ack, viz_ack, dbg_ack}, {e_osc, e_viz, e_dbg});
        s = (cyc + 4) % 16;
        for (int i = 0; i < 4; i++) begin
            if (e_osc[i]) begin
                e_mask[s][i] = 1'b1;
                e_data[s]    = osc_addr[i][15:0] ^ 16'hA5A5;
            end
        end
        if (e_viz) begin e_mask[s][4] = 1'b1; e_data[s] = viz_addr[15:0] ^ 16'hA5A5; end
        if (e_dbg) begin e_mask[s][5] = 1'b1; e_data[s] = dbg_addr[15:0] ^ 16'hA5A5; end
        s = cyc % 16;
        chk("valid", {dbg_valid, viz_valid, osc_valid}, e_mask[s]);
        for (int i = 0; i < 4; i++)
            if (e_mask[s][i]) chk("osc_data", osc_data[i], e_data[s]);
        if (e_mask[s][4]) chk("viz_data", viz_data, e_data[s]);
        if (e_mask[s][5]) chk("dbg_data", dbg_data, e_data[s]);
        e_mask[s] = '0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bram_en"}, bram_en, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_valids"}, {dbg_valid, viz_valid, osc_valid}, 0);
        chk({tag, "_acks"}, {osc_ack, viz_ack, dbg_ack}, 0);
        for (int i = 0; i < 4; i++) chk({tag, "_osc_data"}, osc_data[i], 0);
        chk({tag, "_viz_data"}, viz_data, 0);
        chk({tag, "_dbg_data"}, dbg_data, 0);
    endtask

    initial begin
        logic [3:0] e;
        for (int i = 0; i < 16; i++) begin e_mask[i] = '0; e_data[i] = '0; end
        load_busy = 1'b0; osc_req = '0; viz_req = 1'b0; dbg_req = 1'b0;
        osc_addr[0] = 18'h00010; osc_addr[1] = 18'h01234;
        osc_addr[2] = 18'h2ABCD; osc_addr[3] = 18'h3FFFF;
        viz_addr = 18'h00777; dbg_addr = 18'h00005;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        // While reset is held, acks must be masked even though requests are present.
        osc_req = 4'b1111; viz_req = 1'b1; dbg_req = 1'b1;
        #1;
        chk_outputs_zero("reset");
        osc_req = '0; viz_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: a single osc0 read. The BRAM address appears at T+1 and the data 0xA5B5 at T+4.
        step(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("t1_bram_en", bram_en, 1);
        chk("t1_bram_addr", bram_addr, 18'h00010);
        chk("t1_expect_data", osc_addr[0][15:0] ^ 16'hA5A5, 16'hA5B5);

        // Table: round robin with the pointer starting at 1, then a full rotation and the fallbacks.
        for (int i = 0; i < 3; i++) vt.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0));
        vt.push_back(mk(4'b1000, 0, 0, 0, 4'b1000, 0, 0));   // ptr 1 -> osc3, ptr wraps to 0
        vt.push_back(mk(4'b1111, 0, 0, 0, 4'b0001, 0, 0));
        vt.push_back(mk(4'b1111, 0, 0, 0, 4'b0010, 0, 0));
        vt.push_back(mk(4'b1111, 0, 0, 0, 4'b0100, 0, 0));
        vt.push_back(mk(4'b1111, 0, 0, 0, 4'b1000, 0, 0));
        vt.push_back(mk(4'b1111, 0, 0, 0, 4'b0001, 0, 0));   // ptr now 1
        vt.push_back(mk(4'b0101, 0, 0, 0, 4'b0100, 0, 0));   // first at/after 1 is 2, ptr 3
        vt.push_back(mk(4'b0101, 0, 0, 0, 4'b0001, 0, 0));   // wraps to 0, ptr 1
        vt.push_back(mk(4'b0000, 1, 1, 0, 4'b0000, 1, 0));   // viz beats dbg
        vt.push_back(mk(4'b0000, 0, 1, 0, 4'b0000, 0, 1));
        for (int i = 0; i < 5; i++) vt.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0));
        foreach (vt[i])
            step(vt[i].oreq, vt[i].vreq, vt[i].dreq, vt[i].busy, vt[i].e_osc, vt[i].e_viz, vt[i].e_dbg);

        // Test 4: osc2 is granted, then the loader is busy for 10 cycles while osc1 and dbg wait.
        step(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);      // ptr -> 3
        for (int i = 0; i < 10; i++) begin
            step(4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
            chk("busy_bram_en", bram_en, 0);
        end
        step(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);      // ptr 3 wraps to osc1, ptr -> 2
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        idle(5);

        // Test 3: viz starves behind continuous osc traffic. It is forced after 64 waiting cycles.
        for (int k = 0; k < 66; k++) begin
            e = '0;
            if (k == 65)      e[2] = 1'b1;          // rotation resumes at the unchanged pointer
            else if (k != 64) e[(2 + k) % 4] = 1'b1;
            step(4'b1111, (k < 65), 1'b0, 1'b0, e, (k == 64), 1'b0);
        end
        idle(5);                                     // ptr -> 3

        // Test 6: dbg alone reads addresses 5, 6 and 7 back to back.
        for (int a = 5; a < 8; a++) begin
            dbg_addr = 18'(a);
            step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        end
        idle(5);

        // Test 5: reset is asserted with two reads in flight. They must never return.
        step(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        osc_req = '0; viz_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        for (int i = 0; i < 16; i++) e_mask[i] = '0;
        idle(3);
        rst_n = 1'b1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_read_arbiter.md
Name: wave_read_arbiter

Overview:
Shares the single read port of the wave sample BRAM between NUM_OSC oscillator voices, the visualiser and the UART debugger. It grants one read per cycle, tracks in-flight reads through a fixed-latency tag pipeline, and returns each sample to the requester that issued it. It sits between the oscillators/viz/debug logic and the wave memory inside the memory-management section. Grants stop while the wave loader is rewriting the memory.

Parameters:
NUM_OSC, 4, number of oscillator requesters
ADDR_WIDTH, 18, sample index width (matches WW_WIDTH)
DATA_WIDTH, 16, sample width
READ_LATENCY, 2, BRAM cycles from sampled address to valid read data (minimum 1)
STARVE_LIMIT, 64, cycles viz/debug may wait before a forced grant (minimum 1)

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-low reset
load_busy_in  input  1  wave loader is writing BRAM; no new grants while high
osc_req_in  input  NUM_OSC  per-oscillator read request, level, held until acked
osc_addr_in  input  NUM_OSC x ADDR_WIDTH  per-oscillator sample index, stable while req high
osc_ack_out  output  NUM_OSC  one-hot grant, combinational, in the cycle the request is accepted
osc_valid_out  output  NUM_OSC  one-cycle pulse when osc_data_out[i] is updated
osc_data_out  output  NUM_OSC x DATA_WIDTH  registered returned sample per oscillator
viz_req_in / viz_addr_in / viz_ack_out / viz_valid_out / viz_data_out  same semantics, 1 requester
dbg_req_in / dbg_addr_in / dbg_ack_out / dbg_valid_out / dbg_data_out  same semantics, 1 requester
bram_en_out  output  1  registered read enable
bram_addr_out  output  ADDR_WIDTH  registered read address
bram_data_in  input  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (rst_in low, asynchronous): all acks, valids and bram_en_out = 0; bram_addr_out, all data_out = 0; round-robin pointer = 0; starvation counters = 0; tag pipeline cleared, so in-flight reads are discarded and produce no valid.
- Exactly one ack (or none) per cycle. No ack while load_busy_in = 1. Requests stay pending, and reads already in flight still complete and return.
- Arbitration order in cycle T:
  1. A forced grant first: if the viz counter has reached STARVE_LIMIT, viz wins; otherwise if the dbg counter has reached STARVE_LIMIT, dbg wins.
  2. Otherwise, among the requesting oscillators, the first one at or after the round-robin pointer (wrapping NUM_OSC-1 -> 0) wins.
  3. Otherwise viz, then dbg.
- Round-robin pointer: becomes (winner+1) mod NUM_OSC only when an oscillator is granted; it is unchanged on a viz/dbg grant.
- Starvation counter: increments each cycle its requester has req high without an ack, saturates at STARVE_LIMIT, and clears on ack or when req is low. Counters do not increment while load_busy_in = 1.
- On a grant in cycle T: at the T edge, bram_en_out = 1, bram_addr_out = the winner's address, and the requester tag (0..NUM_OSC-1 = osc, NUM_OSC = viz, NUM_OSC+1 = dbg) plus a valid bit enter the tag pipeline. With no grant, bram_en_out = 0 and bram_addr_out holds its value.
- The tag pipeline has depth READ_LATENCY+1. A valid tag emerging in cycle T+1+READ_LATENCY registers bram_data_in into that requester's data_out and pulses its valid in cycle T+2+READ_LATENCY. Fixed latency from ack to valid is READ_LATENCY+2 (4 by default).
- Back-to-back grants are allowed every cycle (full throughput), and returns come back in grant order.
- data_out holds its last value between returns.
- A requester may re-request the cycle after its ack; multiple outstanding reads per requester are legal.
- A request dropped before ack is simply forgotten. Any request change in the ack cycle itself is a protocol violation and is undefined.

Decomposition:
- Package wave_arb_pkg: tag width function (clog2(NUM_OSC+2)), tag constants TAG_VIZ = NUM_OSC and TAG_DBG = NUM_OSC+1, and a struct {valid, tag} for pipeline entries.
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant out, with an internal pointer updated on grant. It is instantiated once for the oscillators.
- The priority/starvation mux and the tag pipeline stay in the top of this block.

Test Plan:
1. Reset, then osc0 req with addr 0x00010, BRAM model data = addr XOR 0xA5A5 -> osc_ack_out = 0001 in T, bram_addr_out = 0x00010 at T+1, osc_valid_out[0] pulse at T+4 with data 0xA5B5.
2. All 4 osc requesting continuously -> grants cycle 0,1,2,3,0 on consecutive cycles; each return comes 4 cycles after its ack with the correct data.
3. All osc plus viz requesting continuously, STARVE_LIMIT = 64 -> viz acked exactly after 64 waiting cycles; viz_valid_out 4 cycles later; oscillator rotation resumes at the same pointer.
4. Grant osc2 in T and assert load_busy_in from T+1 for 10 cycles with osc1 and dbg requesting -> osc2 data still returns at T+4; no acks and no bram_en_out during busy; osc1 acked in the first cycle after busy drops.
5. Grant osc1 and viz back-to-back, then pull rst_in low at T+2 -> all outputs 0 immediately; no valid pulses after reset release.
6. dbg alone, requesting 3 consecutive addresses 5, 6, 7 -> three acks on consecutive cycles; dbg_valid_out high 3 consecutive cycles with data for 5, 6, 7 in order.
